// File: rtl/regfile_pkg.sv
// Types and widths shared by the register file, the datapath and the writeback queue.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search over the valid entries of the writeback queue.
// Entries are visited from the read pointer (oldest) towards the youngest,
// so the last match found is the youngest one.
module wb_lookup
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]       rd_ptr,
  input  logic [CNT_W-1:0]       count,
  input  logic [REG_ADDR_W-1:0]  lookup_addr,
  output logic                   hit,
  output logic [XLEN-1:0]        data
);

  // Priority search; later (younger) matches overwrite earlier ones.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (lookup_addr != '0) &&
          (entries[idx].addr == lookup_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes and drains them in FIFO
// order, one per cycle, while exposing pending values to two read ports.
module writeback_queue
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_ADDR_W-1:0]  in_addr,
  input  logic [XLEN-1:0]        in_data,
  input  logic                   hold,
  output logic                   write_enable,
  output logic [REG_ADDR_W-1:0]  write_addr,
  output logic [XLEN-1:0]        write_data,
  input  logic [REG_ADDR_W-1:0]  lookup_addr1,
  input  logic [REG_ADDR_W-1:0]  lookup_addr2,
  output logic                   lookup_hit1,
  output logic                   lookup_hit2,
  output logic [XLEN-1:0]        lookup_data1,
  output logic [XLEN-1:0]        lookup_data2,
  output logic [CNT_W-1:0]       count,
  output logic                   empty
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Handshake and drain strobes; rst_n gating keeps both quiet during reset.
  always_comb begin
    in_ready     = rst_n && (count_q < CNT_W'(DEPTH));
    write_enable = rst_n && (count_q != '0) && !hold;
    // Writes to x0 complete the handshake but are dropped.
    push         = in_valid && in_ready && (in_addr != '0);
    pop          = write_enable;
  end

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards all pending entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on each accepted request.
  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wr_ptr_q] <= '{addr: in_addr, data: in_data};
    end
  end

  // Head entry drives the register-file write port.
  always_comb begin
    write_addr = entries_q[rd_ptr_q].addr;
    write_data = entries_q[rd_ptr_q].data;
    count      = count_q;
    empty      = (count_q == '0);
  end

  wb_lookup #(.DEPTH(DEPTH)) u_lookup1 (
    .entries     (entries_q),
    .rd_ptr      (rd_ptr_q),
    .count       (count_q),
    .lookup_addr (lookup_addr1),
    .hit         (lookup_hit1),
    .data        (lookup_data1)
  );

  wb_lookup #(.DEPTH(DEPTH)) u_lookup2 (
    .entries     (entries_q),
    .rd_ptr      (rd_ptr_q),
    .count       (count_q),
    .lookup_addr (lookup_addr2),
    .hit         (lookup_hit2),
    .data        (lookup_data2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_writeback_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_addr;
  logic [31:0]      in_data;
  logic             hold;
  logic             write_enable;
  logic [4:0]       write_addr;
  logic [31:0]      write_data;
  logic [4:0]       lookup_addr1, lookup_addr2;
  logic             lookup_hit1, lookup_hit2;
  logic [31:0]      lookup_data1, lookup_data2;
  logic [CNT_W-1:0] count;
  logic             empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending writes, oldest at the front.
  wb_entry_t model_q [$];

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .hold         (hold),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .lookup_addr1 (lookup_addr1),
    .lookup_addr2 (lookup_addr2),
    .lookup_hit1  (lookup_hit1),
    .lookup_hit2  (lookup_hit2),
    .lookup_data1 (lookup_data1),
    .lookup_data2 (lookup_data2),
    .count        (count),
    .empty        (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Youngest pending value for an index; x0 never hits.
  function automatic void model_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a == 0) return;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].addr == a) begin
        hit = 1'b1;
        d   = model_q[i].data;
        return;
      end
    end
  endfunction

  // One clock cycle: inputs already driven after the falling edge.
  task automatic cycle(input string tag);
    logic        exp_ready, exp_we, h1, h2;
    logic [31:0] d1, d2;
    #1;
    if (!rst_n) model_q.delete();
    exp_ready = rst_n && (model_q.size() < DEPTH);
    exp_we    = rst_n && (model_q.size() > 0) && !hold;
    model_lookup(lookup_addr1, h1, d1);
    model_lookup(lookup_addr2, h2, d2);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".write_enable"}, 32'(write_enable), 32'(exp_we));
    if (exp_we) begin
      check({tag, ".write_addr"}, 32'(write_addr), 32'(model_q[0].addr));
      check({tag, ".write_data"}, write_data, model_q[0].data);
    end
    check({tag, ".hit1"}, 32'(lookup_hit1), 32'(h1));
    check({tag, ".data1"}, lookup_data1, d1);
    check({tag, ".hit2"}, 32'(lookup_hit2), 32'(h2));
    check({tag, ".data2"}, lookup_data2, d2);
    @(posedge clk);
    if (rst_n) begin
      if (exp_we) void'(model_q.pop_front());
      if (in_valid && exp_ready && in_addr != 0)
        model_q.push_back('{addr: in_addr, data: in_data});
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    hold     = h;
  endtask

  task automatic idle(input string tag, input int n);
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    lookup_addr1 = 5'd0;
    lookup_addr2 = 5'd0;
    @(negedge clk);
    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;

    // Single write with minimum latency.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    lookup_addr1 = 5'd5;
    cycle("single_enq");
    idle("single_drain", 2);

    // Fill under hold, reject a fifth request, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i), 1'b1);
      cycle("fill");
    end
    drive(1'b1, 5'd5, 32'd5, 1'b1);
    cycle("full_reject");
    idle("full_drain", 5);

    // Youngest match wins; x0 lookup never hits.
    drive(1'b1, 5'd7, 32'h11, 1'b1);
    cycle("lk_enq1");
    drive(1'b1, 5'd7, 32'h22, 1'b1);
    cycle("lk_enq2");
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    lookup_addr1 = 5'd7;
    lookup_addr2 = 5'd0;
    cycle("lk_hold");
    idle("lk_drain", 3);

    // Write to x0 is accepted but dropped.
    drive(1'b1, 5'd0, 32'h55, 1'b0);
    cycle("x0_enq");
    idle("x0_after", 2);

    // Reset pulse with pending entries discards them.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 32'(100 + i), 1'b1);
      cycle("pre_rst");
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    cycle("rst_pulse");
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 32'h9, 1'b0);
    lookup_addr1 = 5'd3;
    cycle("post_rst_enq");
    idle("post_rst_drain", 2);

    // Full queue with continuous requests and draining.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 5'(20 + i), 32'(200 + i), 1'b1);
      cycle("stream_fill");
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
      cycle("stream");
    end
    idle("stream_drain", DEPTH + 1);

    // Random traffic with a narrow address range to provoke lookup hits.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 3));
      lookup_addr1 = 5'($urandom_range(0, 7));
      lookup_addr2 = 5'($urandom_range(0, 7));
      cycle("random");
    end
    idle("final_drain", DEPTH + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
